// File: rtl/imm_gen_stage_if.sv
// Handshaked bus for imm_gen_stage: upstream instruction side and downstream immediate side.
// The master drives the instruction and out_ready; the slave (the stage itself) drives the rest.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:7]     instr;
    logic [2:0]      immsrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immext;
    logic            imm_err;

    modport master (
        output in_valid, instr, immsrc, out_ready,
        input  in_ready, out_valid, immext, imm_err
    );

    modport slave (
        input  in_valid, instr, immsrc, out_ready,
        output in_ready, out_valid, immext, imm_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer (output register + skid register).
// Accepts one instruction per cycle and absorbs one cycle of downstream backpressure.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              reset,
    input logic              flush,
    imm_gen_stage_if.slave   bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic            s;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    logic            or_valid;
    logic [XLEN-1:0] or_imm;
    logic            or_err;
    logic            sk_valid;
    logic [XLEN-1:0] sk_imm;
    logic            sk_err;

    logic            acc;
    logic            drn;

    assign s   = bus.instr[31];
    assign acc = bus.in_valid & ~sk_valid;
    assign drn = or_valid & bus.out_ready;

    // Format decode; the illegal select still produces defined bits (zero) plus the error flag.
    always_comb begin
        dec_imm = '0;
        dec_err = 1'b0;
        case (bus.immsrc)
            3'b000: dec_imm = {{(XLEN-12){s}}, bus.instr[31:20]};
            3'b001: dec_imm = {{(XLEN-12){s}}, bus.instr[31:25], bus.instr[11:7]};
            3'b010: dec_imm = {{(XLEN-12){s}}, bus.instr[7], bus.instr[30:25],
                               bus.instr[11:8], 1'b0};
            3'b011: dec_imm = {{(XLEN-20){s}}, bus.instr[19:12], bus.instr[20],
                               bus.instr[30:21], 1'b0};
            3'b100: dec_imm = {{(XLEN-31){s}}, bus.instr[30:12], 12'b0};
            3'b101: dec_imm = {{(XLEN-5){1'b0}}, bus.instr[19:15]};
            3'b110: begin
                if (XLEN == 64) begin
                    dec_imm = {{(XLEN-6){1'b0}}, bus.instr[25:20]};
                end else begin
                    dec_imm = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
                end
            end
            default: begin
                dec_imm = '0;
                dec_err = 1'b1;
            end
        endcase
    end

    // OR refills from SK first so ordering stays FIFO; a new input only lands in OR when SK is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid <= 1'b0;
            or_imm   <= '0;
            or_err   <= 1'b0;
            sk_valid <= 1'b0;
            sk_imm   <= '0;
            sk_err   <= 1'b0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (!or_valid || drn) begin
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_imm   <= sk_imm;
                or_err   <= sk_err;
                if (acc) begin
                    sk_imm <= dec_imm;
                    sk_err <= dec_err;
                end else begin
                    sk_valid <= 1'b0;
                end
            end else if (acc) begin
                or_valid <= 1'b1;
                or_imm   <= dec_imm;
                or_err   <= dec_err;
            end else begin
                or_valid <= 1'b0;
            end
        end else if (acc) begin
            sk_valid <= 1'b1;
            sk_imm   <= dec_imm;
            sk_err   <= dec_err;
        end
    end

    assign bus.in_ready  = ~sk_valid;
    assign bus.out_valid = or_valid;
    assign bus.immext    = or_imm;
    assign bus.imm_err   = or_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: drives XLEN=32 and XLEN=64 instances in lockstep and checks both
// against an arithmetic decoder plus a 2-deep FIFO model of the stage.
module tb_imm_gen_stage;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:7] instr;
    logic [2:0]  immsrc;

    int          errors = 0;
    int          checks = 0;
    entry_t      q[$];
    bit          last_accepted;
    bit          after_reset;
    logic [31:0] got[$];
    int          k;

    imm_gen_stage_if #(.XLEN(32)) bus32 ();
    imm_gen_stage_if #(.XLEN(64)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.instr     = instr;
    assign bus32.immsrc    = immsrc;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.instr     = instr;
    assign bus64.immsrc    = immsrc;
    assign bus64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(bus32));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(bus64));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Immediate assembled from the full instruction word with shifts and masks.
    function automatic logic [63:0] refDecode(input int xlen, input logic [31:7] ins,
                                              input logic [2:0] sel);
        logic [31:0] w;
        logic [63:0] sgn;
        logic [63:0] r;
        w   = {ins, 7'b0};
        sgn = {64{w[31]}};
        case (sel)
            3'd0: r = (sgn << 12) | 64'(w[31:20]);
            3'd1: r = (sgn << 12) | (64'(w[31:25]) << 5) | 64'(w[11:7]);
            3'd2: r = (sgn << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
            3'd3: r = (sgn << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
            3'd4: r = (sgn << 32) | (64'(w[31:12]) << 12);
            3'd5: r = 64'(w[19:15]);
            3'd6: r = (xlen == 64) ? 64'(w[25:20]) : 64'(w[24:20]);
            default: r = 64'd0;
        endcase
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    task automatic modelEdge();
        entry_t e;
        bit     rdy;
        last_accepted = 1'b0;
        after_reset   = 1'b0;
        if (reset) begin
            q.delete();
            after_reset = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                e.e32 = refDecode(32, instr, immsrc);
                e.e64 = refDecode(64, instr, immsrc);
                e.err = (immsrc == 3'b111);
                q.push_back(e);
                last_accepted = 1'b1;
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
        checkOutput("valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
        checkOutput("ready32", 64'(bus32.in_ready), 64'(q.size() < 2));
        checkOutput("ready64", 64'(bus64.in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            checkOutput("imm32", 64'(bus32.immext), q[0].e32);
            checkOutput("imm64", bus64.immext, q[0].e64);
            checkOutput("err32", 64'(bus32.imm_err), 64'(q[0].err));
            checkOutput("err64", 64'(bus64.imm_err), 64'(q[0].err));
        end
        if (after_reset) begin
            checkOutput("rstimm32", 64'(bus32.immext), 64'd0);
            checkOutput("rstimm64", bus64.immext, 64'd0);
            checkOutput("rsterr32", 64'(bus32.imm_err), 64'd0);
        end
    endtask

    // Inputs change at the falling edge; the model steps at the rising edge, outputs are checked at the next fall.
    task automatic applyStimulus(input logic v, input logic [31:7] ins, input logic [2:0] sel,
                                 input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        instr     = ins;
        immsrc    = sel;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; immsrc = '0;

        applyStimulus(0, '0, 3'd0, 0, 0, 1);
        applyStimulus(0, '0, 3'd0, 0, 0, 1);
        checkOutput("rst_ready", 64'(bus32.in_ready), 64'd1);

        applyStimulus(1, 25'h1FFFF80, 3'b000, 1, 0, 0);
        checkOutput("dir_i_neg", 64'(bus32.immext), 64'hFFFF_FFFF);
        applyStimulus(1, 25'h1FFFFFF, 3'b100, 1, 0, 0);
        checkOutput("dir_u_neg", 64'(bus32.immext), 64'hFFFF_F000);
        applyStimulus(1, 25'h001E001, 3'b000, 1, 0, 0);
        checkOutput("dir_i_15", 64'(bus32.immext), 64'h0000_000F);
        applyStimulus(1, 25'h0001F00, 3'b101, 1, 0, 0);
        checkOutput("dir_zimm", 64'(bus32.immext), 64'h0000_001F);
        applyStimulus(1, 25'h1FFFFFF, 3'b111, 1, 0, 0);
        checkOutput("dir_ill_imm", 64'(bus32.immext), 64'd0);
        checkOutput("dir_ill_err", 64'(bus32.imm_err), 64'd1);
        applyStimulus(1, 25'h1000000, 3'b100, 1, 0, 0);
        checkOutput("dir_u64", bus64.immext, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1, 25'h007E000, 3'b110, 1, 0, 0);
        checkOutput("dir_sh64", bus64.immext, 64'h3F);
        checkOutput("dir_sh32", 64'(bus32.immext), 64'h1F);
        applyStimulus(0, '0, 3'd0, 1, 0, 0);

        // Backpressure: offer imms 1..4 while the downstream stalls, then release it.
        k = 1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(k <= 4, 25'(k) << 13, 3'b000, 0, 0, 0);
            if (last_accepted) k++;
        end
        checkOutput("bp_ready_low", 64'(bus32.in_ready), 64'd0);
        checkOutput("bp_held", 64'(bus32.immext), 64'd1);
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (bus32.out_valid) got.push_back(bus32.immext);
            applyStimulus(k <= 4, 25'(k) << 13, 3'b000, 1, 0, 0);
            if (last_accepted) k++;
        end
        checkOutput("bp_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size() && i < 4; i++)
            checkOutput("bp_order", 64'(got[i]), 64'(i + 1));

        applyStimulus(1, 25'(5) << 13, 3'b000, 0, 0, 0);
        applyStimulus(1, 25'(6) << 13, 3'b000, 0, 0, 0);
        applyStimulus(1, 25'(7) << 13, 3'b000, 0, 1, 0);
        checkOutput("flush_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("flush_ready", 64'(bus32.in_ready), 64'd1);
        for (int c = 0; c < 3; c++) applyStimulus(0, '0, 3'd0, 1, 0, 0);

        applyStimulus(1, 25'(8) << 13, 3'b000, 0, 0, 0);
        applyStimulus(1, 25'(9) << 13, 3'b000, 0, 0, 0);
        applyStimulus(1, 25'(10) << 13, 3'b000, 1, 0, 1);
        checkOutput("mrst_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("mrst_imm", 64'(bus32.immext), 64'd0);
        checkOutput("mrst_err", 64'(bus32.imm_err), 64'd0);
        checkOutput("mrst_ready", 64'(bus32.in_ready), 64'd1);
        applyStimulus(1, 25'(11) << 13, 3'b000, 1, 0, 0);
        checkOutput("mrst_first", 64'(bus32.immext), 64'd11);
        applyStimulus(0, '0, 3'd0, 1, 0, 0);

        for (int c = 0; c < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, 25'($urandom), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
                          $urandom_range(0, 499) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
